// File: rtl/inst_fetch.sv
// Instruction-fetch stage: issues pc to instruction memory and pairs in-order responses
// with their addresses in a small circular buffer before handing {pc, inst} to decode.
module inst_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ce,
  input  logic              flush,
  output logic              stallreq,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  input  logic              id_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W-1:0]  r_fill;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_pending;
  logic [ADDR_W-1:0] r_slotPc   [DEPTH];
  logic [DATA_W-1:0] r_slotInst [DEPTH];
  logic [DEPTH-1:0]  r_filled;
  logic [DEPTH-1:0]  r_killed;

  logic w_accept;
  logic w_respHit;
  logic w_headReady;
  logic w_pop;

  // Responses arrive in order, so filled slots always form a prefix starting at head;
  // r_fill / r_pending track the oldest occupied slot still waiting for its word.
  assign w_respHit   = imem_resp_valid & (r_pending != '0);
  assign w_headReady = (r_count != '0) & r_filled[r_head];

  assign imem_req_valid = rst & ce & ~flush & (r_count < CNT_W'(DEPTH));
  assign imem_req_addr  = pc;
  assign w_accept       = imem_req_valid & imem_req_ready;
  assign stallreq       = rst & ce & ~flush & ~w_accept;

  assign if_valid = rst & ~flush & w_headReady & ~r_killed[r_head];
  assign if_pc    = r_slotPc[r_head];
  assign if_inst  = r_slotInst[r_head];

  // Killed words retire silently, one per cycle, without ever reaching decode.
  assign w_pop = w_headReady & (r_killed[r_head] | (if_valid & id_ready));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_fill    <= '0;
      r_count   <= '0;
      r_pending <= '0;
    end else begin
      if (w_accept) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_respHit) begin
        r_fill <= r_fill + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count   <= r_count + {{(CNT_W-1){1'b0}}, w_accept} - {{(CNT_W-1){1'b0}}, w_pop};
      r_pending <= r_pending + {{(CNT_W-1){1'b0}}, w_accept} - {{(CNT_W-1){1'b0}}, w_respHit};
    end
  end

  // Tail and the fill target never coincide: tail is free, the fill target is occupied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_filled <= '0;
      r_killed <= '0;
    end else begin
      if (w_accept) begin
        r_filled[r_tail] <= 1'b0;
      end
      if (w_respHit) begin
        r_filled[r_fill] <= 1'b1;
      end
      if (flush) begin
        r_killed <= '1;
      end else if (w_accept) begin
        r_killed[r_tail] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slotPc[i]   <= '0;
        r_slotInst[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_slotPc[r_tail] <= pc;
      end
      if (w_respHit) begin
        r_slotInst[r_fill] <= imem_resp_data;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a cycle table drives the pc stage, memory and decode,
// and hand sequences cover flush and mid-operation reset.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        ce;
  logic        flush;
  logic        stallreq;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;

  typedef struct {
    bit          ce;
    bit          rqRdy;
    bit          idRdy;
    bit          respEn;
    bit          flush;
    logic [31:0] tgt;
    bit          expRqV;
    bit          expStall;
    bit          expIfV;
    logic [31:0] expPc;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] memQ[$];
  int          errors = 0;
  int          checks = 0;

  inst_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .ce              (ce),
    .flush           (flush),
    .stallreq        (stallreq),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .id_ready        (id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instOf(input logic [31:0] a);
    return 32'hC0DE_0000 ^ (a << 4) ^ a;
  endfunction

  function automatic vec_t mk(input bit c, input bit rr, input bit ir, input bit re,
                              input bit fl, input logic [31:0] t, input bit eRv,
                              input bit eSt, input bit eIv, input logic [31:0] ePc);
    vec_t v;
    v.ce = c; v.rqRdy = rr; v.idRdy = ir; v.respEn = re; v.flush = fl; v.tgt = t;
    v.expRqV = eRv; v.expStall = eSt; v.expIfV = eIv; v.expPc = ePc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
    end
  endtask

  // Memory answers one queued request per cycle when enabled; the pc stage follows stallreq.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [31:0] nextPc;
    ce             = v.ce;
    imem_req_ready = v.rqRdy;
    id_ready       = v.idRdy;
    flush          = v.flush;
    if (v.respEn && memQ.size() > 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = instOf(memQ.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    #1;
    checkOutput($sformatf("c%0d req_valid", idx), 32'(imem_req_valid), 32'(v.expRqV));
    checkOutput($sformatf("c%0d stallreq", idx), 32'(stallreq), 32'(v.expStall));
    checkOutput($sformatf("c%0d if_valid", idx), 32'(if_valid), 32'(v.expIfV));
    if (v.expRqV) checkOutput($sformatf("c%0d req_addr", idx), imem_req_addr, pc);
    if (v.expIfV) begin
      checkOutput($sformatf("c%0d if_pc", idx), if_pc, v.expPc);
      checkOutput($sformatf("c%0d if_inst", idx), if_inst, instOf(v.expPc));
    end
    if (imem_req_valid && imem_req_ready) memQ.push_back(imem_req_addr);
    if (v.flush) nextPc = v.tgt;
    else if (v.ce && !stallreq) nextPc = pc + 32'h4;
    else nextPc = pc;
    @(posedge clk);
    #1;
    pc    = nextPc;
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0; pc = '0; ce = 1'b1; flush = 1'b0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0; id_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("reset stallreq", 32'(stallreq), 32'd0);
    checkOutput("reset if_valid", 32'(if_valid), 32'd0);
    checkOutput("reset if_pc", if_pc, 32'd0);
    checkOutput("reset if_inst", if_inst, 32'd0);
    rst = 1'b1;

    // Stream, ce-drain, memory backpressure at 0x10, decode backpressure, then build-up.
    vecs.push_back(mk(1,1,1,1,0,0, 1,0,0,32'h0));
    vecs.push_back(mk(1,1,1,1,0,0, 1,0,0,32'h0));
    vecs.push_back(mk(1,1,1,1,0,0, 1,0,1,32'h0));
    vecs.push_back(mk(1,1,1,1,0,0, 1,0,1,32'h4));
    vecs.push_back(mk(0,1,1,1,0,0, 0,0,1,32'h8));
    vecs.push_back(mk(0,1,1,1,0,0, 0,0,1,32'hC));
    vecs.push_back(mk(1,0,1,1,0,0, 1,1,0,32'h0));
    vecs.push_back(mk(1,0,1,1,0,0, 1,1,0,32'h0));
    vecs.push_back(mk(1,0,1,1,0,0, 1,1,0,32'h0));
    vecs.push_back(mk(1,1,1,1,0,0, 1,0,0,32'h0));
    vecs.push_back(mk(1,1,0,1,0,0, 1,0,0,32'h0));
    vecs.push_back(mk(1,1,0,1,0,0, 1,0,1,32'h10));
    vecs.push_back(mk(1,1,0,1,0,0, 1,0,1,32'h10));
    vecs.push_back(mk(1,1,0,1,0,0, 0,1,1,32'h10));
    vecs.push_back(mk(1,1,0,1,0,0, 0,1,1,32'h10));
    vecs.push_back(mk(1,1,0,1,0,0, 0,1,1,32'h10));
    vecs.push_back(mk(1,1,1,1,0,0, 0,1,1,32'h10));
    vecs.push_back(mk(1,1,1,1,0,0, 1,0,1,32'h14));
    vecs.push_back(mk(1,1,1,1,0,0, 1,0,1,32'h18));
    vecs.push_back(mk(1,1,1,1,0,0, 1,0,1,32'h1C));
    vecs.push_back(mk(1,1,1,1,0,0, 1,0,1,32'h20));
    vecs.push_back(mk(0,1,1,1,0,0, 0,0,1,32'h24));
    vecs.push_back(mk(0,1,1,1,0,0, 0,0,1,32'h28));
    vecs.push_back(mk(0,1,1,1,0,0, 0,0,1,32'h2C));
    vecs.push_back(mk(1,1,0,0,0,0, 1,0,0,32'h0));
    vecs.push_back(mk(1,1,0,1,0,0, 1,0,0,32'h0));
    vecs.push_back(mk(1,1,0,0,0,0, 1,0,1,32'h30));
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // Flush with one filled and two pending slots; killed words must never surface.
    applyStimulus(mk(1,1,1,0,1,32'h100, 0,0,0,32'h0), 27);
    applyStimulus(mk(1,1,1,1,0,0,       1,0,0,32'h0), 28);
    applyStimulus(mk(1,1,1,1,0,0,       1,0,0,32'h0), 29);
    applyStimulus(mk(1,1,1,1,0,0,       1,0,0,32'h0), 30);
    applyStimulus(mk(1,1,1,1,0,0,       1,0,1,32'h100), 31);

    // Flush coinciding with a response: that word lands killed and is discarded.
    applyStimulus(mk(1,1,1,1,1,32'h200, 0,0,0,32'h0), 32);
    applyStimulus(mk(1,1,1,1,0,0,       1,0,0,32'h0), 33);
    applyStimulus(mk(1,1,1,1,0,0,       1,0,0,32'h0), 34);
    applyStimulus(mk(1,1,1,1,0,0,       1,0,0,32'h0), 35);
    applyStimulus(mk(1,1,1,1,0,0,       1,0,1,32'h200), 36);

    // Asynchronous reset with three occupied slots, then a clean restart at 0x300.
    rst = 1'b0;
    #1;
    checkOutput("midreset req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("midreset stallreq", 32'(stallreq), 32'd0);
    checkOutput("midreset if_valid", 32'(if_valid), 32'd0);
    checkOutput("midreset if_pc", if_pc, 32'd0);
    checkOutput("midreset if_inst", if_inst, 32'd0);
    memQ.delete();
    imem_resp_valid = 1'b0;
    @(posedge clk);
    #1;
    pc  = 32'h300;
    rst = 1'b1;
    applyStimulus(mk(1,1,1,1,0,0, 1,0,0,32'h0), 100);
    applyStimulus(mk(1,1,1,1,0,0, 1,0,0,32'h0), 101);
    applyStimulus(mk(1,1,1,1,0,0, 1,0,1,32'h300), 102);
    applyStimulus(mk(1,1,1,1,0,0, 1,0,1,32'h304), 103);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage between the `pc` stage and decode. It issues the current `pc` to instruction memory through a valid/ready request channel and matches in-order responses to their addresses in a small in-order buffer. It presents `{pc, inst}` pairs to decode with a valid/ready handshake. It drives `stallreq` back to `pc` so the PC advances only when a fetch is accepted, and squashes all younger work on `flush` (branch taken).

## Interface
- `ADDR_W`, 32, instruction address width
- `DATA_W`, 32, instruction width
- `DEPTH`, 4, buffer slots and maximum outstanding fetches; power of two, ≥2
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `pc`  in  ADDR_W  fetch address from `pc` stage
- `ce`  in  1  `pc` stage enable; no fetch while low
- `flush`  in  1  branch taken this cycle, the same cycle `br` is presented to `pc`
- `stallreq`  out  1  hold `pc`
- `imem_req_valid`  out  1  fetch request
- `imem_req_addr`  out  ADDR_W  equals `pc`
- `imem_req_ready`  in  1  memory accepts request
- `imem_resp_valid`  in  1  response beat, in request order, ≥1 cycle after acceptance
- `imem_resp_data`  in  DATA_W  instruction word
- `if_valid`  out  1  instruction available to decode
- `if_pc`  out  ADDR_W  address of presented instruction
- `if_inst`  out  DATA_W  presented instruction
- `id_ready`  in  1  decode accepts

## Operation
- **Buffer.** A circular buffer of `DEPTH` slots tracked by `head`, `tail` and `count`.
  - Each slot holds `pc`, `inst` and the flags `filled` and `killed`.
  - `count` is `$clog2(DEPTH)+1` bits.
- **Request.** `imem_req_valid = rst & ce & ~flush & (count < DEPTH)`.
  - `count` is the registered value. A pop in the same cycle does not free a slot.
  - Acceptance means `imem_req_valid & imem_req_ready`.
  - On acceptance, the slot at `tail` is allocated with `pc`, `filled=0`, `killed=0`, and `tail` increments.
- **Stall.** `stallreq = rst & ce & ~flush & ~accept`.
  - `flush` always deasserts `stallreq`, so `pc` takes the branch target. That cycle's sequential address is not fetched.
- **Response.** A response writes `imem_resp_data` into the oldest unfilled slot and sets `filled`.
  - A response with no unfilled occupied slot is a protocol violation and is ignored.
  - Responses are never backpressured.
- **Output.**
  - `if_valid = rst & ~flush & occupied(head) & filled(head) & ~killed(head)`.
  - `if_pc` and `if_inst` come from the `head` slot.
  - A transfer occurs on `if_valid & id_ready`. It pops `head`.
- **Killed slots.** A head slot with `filled & killed` pops in one cycle without asserting `if_valid`. At most one pop occurs per cycle.
- **Flush.** Every occupied slot is marked `killed`. No allocation occurs that cycle.
  - In-flight responses still land in their killed slots and are then discarded.
  - Slot accounting stays exact, and no stale instruction reaches decode.
- **Simultaneous events.** Allocation, fill and pop may happen in the same cycle. `count` update = +accept − pop.
- **Flush and response together.** When `flush` and a response coincide, the response fills its slot and that slot is killed.
- **Reset.** `rst` low clears `head`, `tail` and `count` to 0 and all flags to 0, at any time including mid-operation. In-flight memory responses after reset are the memory's responsibility to drop.

## Timing
- **Reset values.** `imem_req_valid=0`, `stallreq=0`, `if_valid=0`. `if_pc` and `if_inst` are don't-care; register them as 0.
- **Latency.** With a 1-cycle memory, the request is accepted in cycle t, the response arrives in cycle t+1, and `if_valid` is asserted in cycle t+2.
- **Throughput.** With `DEPTH≥3`, 1-cycle memory and `id_ready` held high, steady state is one instruction per cycle.
- **Output stability.** While `if_valid & ~id_ready`, `if_pc` and `if_inst` hold stable.
- **`flush` is combinational on outputs.** It forces `if_valid=0`, `imem_req_valid=0` and `stallreq=0` in the same cycle.
- **Full buffer.** With `count==DEPTH`, `imem_req_valid=0` and `stallreq=1` (when `ce=1`).

## Test plan
- **Reset then stream.** Release `rst`, `ce=1`, `pc` from 0x0, 1-cycle memory, `id_ready=1`.
  - Required: `if_pc` = 0x0, 0x4, 0x8, 0xC on consecutive cycles, first 2 cycles after the first acceptance; `stallreq` never high.
- **Memory backpressure.** `imem_req_ready=0` for 3 cycles at `pc=0x10`.
  - Required: `stallreq=1` for those 3 cycles, `imem_req_addr` holds 0x10, no `if_valid`.
  - On release, 0x10 is presented once.
- **Decode backpressure.** `id_ready=0` for 6 cycles.
  - Required: `if_pc` and `if_inst` stable; `count` reaches 4; `imem_req_valid=0` and `stallreq=1`.
  - On release, 4 instructions drain in order.
- **Flush with outstanding.** Flush with 2 pending and 1 filled slot; memory responds to the pending slots afterwards; new target 0x100.
  - Required: the 3 killed instructions never assert `if_valid`.
  - Required: the next `if_pc` is 0x100, with `stallreq=0` in the flush cycle.
- **Same-cycle collisions.** Response, acceptance and `id_ready` pop in the same cycle.
  - Required: `count` unchanged, ordering preserved.
  - Flush coinciding with a response: that response is discarded.
- **Reset mid-operation.** Assert `rst` low with 3 occupied slots.
  - Required: all outputs 0 immediately (asynchronous), `count=0`.
  - Fetch restarts cleanly after release.
